// File: rtl/sha1_msg_padder.sv
// sha1_msg_padder: SHA-1 padding and 512-bit block framing for the core.
// Define SHA1_PAD_ERR_EN to enable sticky input-protocol error checking.
module sha1_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_bytes,
  input  logic         in_last,
  output logic         blk_valid,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last,
  input  logic         blk_ack,
  output logic         err
);

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    EXTRA
  } st_t;

  st_t r_state;
  st_t w_nxt;

  logic [15:0][31:0] r_blk;
  logic [3:0]        r_idx;
  logic [LEN_W-1:0]  r_bitlen;
  logic              r_first;
  logic              r_last;
  logic              r_pend;
  logic              r_pend80;

  logic [2:0]        w_nb;
  logic              w_bad;
  logic              w_acc;
  logic              w_take;
  logic [LEN_W-1:0]  w_inc;
  logic [LEN_W-1:0]  w_sum;
  logic [63:0]       w_len_new;
  logic [63:0]       w_len_cur;
  logic [31:0]       w_word;
  logic [4:0]        w_p;

`ifdef SHA1_PAD_ERR_EN
  logic r_err;

  assign w_nb  = in_bytes;
  assign w_bad = (in_bytes > 3'd4)
              || ((in_bytes < 3'd4) && !in_last)
              || (w_sum < r_bitlen);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_err <= 1'b0;
    else if (clr)
      r_err <= 1'b0;
    else if (w_acc && w_bad)
      r_err <= 1'b1;
  end

  assign err = r_err;
`else
  // Short non-last words count as full; oversize counts clamp to 4.
  assign w_nb  = !in_last ? 3'd4
               : (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign w_bad = 1'b0;
  assign err   = 1'b0;
`endif

  assign w_inc  = {{(LEN_W-6){1'b0}}, w_nb, 3'b000};
  assign w_sum  = r_bitlen + w_inc;
  assign w_acc  = in_valid && in_ready && !clr;
  assign w_take = w_acc && !w_bad;
  assign w_p    = (w_nb < 3'd4) ? {1'b0, r_idx}
                : {1'b0, r_idx} + 5'd1;

  always_comb begin
    w_len_new = '0;
    w_len_new[LEN_W-1:0] = w_sum;
    w_len_cur = '0;
    w_len_cur[LEN_W-1:0] = r_bitlen;
  end

  // Keep valid bytes, drop the 0x80 marker right after them, zero the rest.
  always_comb begin
    w_word = in_data;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) == w_nb)
        w_word[31-8*b -: 8] = 8'h80;
      else if (3'(b) > w_nb)
        w_word[31-8*b -: 8] = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= FILL;
    else
      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      FILL:
        if (w_take && (in_last || r_idx == 4'd15))
          w_nxt = EMIT;
      EMIT:
        if (blk_ack)
          w_nxt = r_pend ? EXTRA : FILL;
      EXTRA:
        w_nxt = EMIT;
      default:
        w_nxt = FILL;
    endcase
    if (clr)
      w_nxt = FILL;
  end

  always_comb begin
    in_ready  = (r_state == FILL) && !reset;
    blk_valid = (r_state == EMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blk    <= '0;
      r_idx    <= '0;
      r_bitlen <= '0;
      r_first  <= 1'b1;
      r_last   <= 1'b0;
      r_pend   <= 1'b0;
      r_pend80 <= 1'b0;
    end else if (clr) begin
      r_idx    <= '0;
      r_bitlen <= '0;
      r_first  <= 1'b1;
      r_last   <= 1'b0;
      r_pend   <= 1'b0;
      r_pend80 <= 1'b0;
    end else begin
      if (w_take) begin
        r_bitlen     <= w_sum;
        r_idx        <= in_last ? 4'd0 : r_idx + 4'd1;
        r_blk[r_idx] <= w_word;
        r_last       <= in_last && (w_p <= 5'd13);
        if (in_last) begin
          for (int i = 0; i < 16; i++) begin
            if (4'(i) > r_idx)
              r_blk[i] <= (w_p == 5'(i)) ? 32'h8000_0000 : 32'h0;
          end
          if (w_p <= 5'd13) begin
            r_blk[14] <= w_len_new[63:32];
            r_blk[15] <= w_len_new[31:0];
          end
          r_pend   <= (w_p > 5'd13);
          r_pend80 <= (w_p == 5'd16);
        end
      end
      if (r_state == EXTRA) begin
        r_blk     <= '0;
        r_blk[0]  <= r_pend80 ? 32'h8000_0000 : 32'h0;
        r_blk[14] <= w_len_cur[63:32];
        r_blk[15] <= w_len_cur[31:0];
        r_last    <= 1'b1;
        r_pend    <= 1'b0;
        r_pend80  <= 1'b0;
      end
      if (r_state == EMIT && blk_ack) begin
        r_first <= r_last;
        if (r_last) begin
          r_bitlen <= '0;
          r_idx    <= '0;
        end
      end
    end
  end

  assign blk_data  = r_blk;
  assign blk_first = r_first;
  assign blk_last  = r_last;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// tb_sha1_msg_padder: directed and random messages checked against a
// byte-level SHA-1 padding model.
module tb_sha1_msg_padder;

  typedef byte unsigned bq_t[$];

  logic         clk = 1'b0;
  logic         reset;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         in_last;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         blk_ack;
  logic         err;

  int checks = 0;
  int errors = 0;
  logic [511:0] exp_q[$];

  always #5 clk = ~clk;

  sha1_msg_padder dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bytes  (in_bytes),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .blk_ack   (blk_ack),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Standard SHA-1 padding of a byte string, cut into 512-bit blocks.
  task automatic model(input bq_t m);
    bq_t p;
    logic [63:0] bl;
    logic [511:0] x;
    p = m;
    bl = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    exp_q.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      x = '0;
      for (int j = 0; j < 64; j++)
        x[32*(j/4) + 31 - 8*(j%4) -: 8] = p[64*b + j];
      exp_q.push_back(x);
    end
  endtask

  task automatic mk(input int n, output bq_t m);
    m.delete();
    for (int i = 0; i < n; i++) m.push_back(8'($urandom()));
  endtask

  task automatic send(input bq_t m, input int dly, input string tag);
    logic [31:0] wd[$];
    logic [2:0]  wb[$];
    bit          wl[$];
    logic [31:0] w;
    int n, wi, bi, cyc;
    n = m.size();
    model(m);
    for (int i = 0; i + 4 <= n; i += 4) begin
      w = {m[i], m[i+1], m[i+2], m[i+3]};
      wd.push_back(w); wb.push_back(3'd4); wl.push_back(1'b0);
    end
    if (n % 4 != 0) begin
      w = $urandom();
      for (int k = 0; k < n % 4; k++) w[31-8*k -: 8] = m[n - n%4 + k];
      wd.push_back(w); wb.push_back(3'(n % 4)); wl.push_back(1'b1);
    end else if (n == 0 || $urandom_range(0, 1) == 1) begin
      wd.push_back($urandom()); wb.push_back(3'd0); wl.push_back(1'b1);
    end else begin
      wl[wl.size()-1] = 1'b1;
`ifndef SHA1_PAD_ERR_EN
      if ($urandom_range(0, 2) == 0)
        wb[wb.size()-1] = 3'($urandom_range(5, 7));
`endif
    end
`ifndef SHA1_PAD_ERR_EN
    for (int i = 0; i + 1 < wd.size(); i++)
      if ($urandom_range(0, 3) == 0) wb[i] = 3'($urandom_range(0, 3));
`endif
    wi = 0; bi = 0; cyc = 0;
    while (bi < exp_q.size() && cyc < 3000) begin
      @(negedge clk); cyc++;
      in_valid = 1'b0; blk_ack = 1'b0;
      if (blk_valid) begin
        chk({tag, "_data"}, blk_data, exp_q[bi]);
        chk({tag, "_first"}, blk_first, bi == 0);
        chk({tag, "_last"}, blk_last, bi == exp_q.size() - 1);
        for (int d = 0; d < dly; d++) begin
          @(negedge clk); cyc++;
          chk({tag, "_hold"}, blk_data, exp_q[bi]);
          chk({tag, "_hold_rdy"}, {blk_valid, in_ready}, 2'b10);
        end
        blk_ack = 1'b1; bi++;
      end else if (in_ready && wi < wd.size() && $urandom_range(0, 3) != 0) begin
        in_data = wd[wi]; in_bytes = wb[wi]; in_last = wl[wi];
        in_valid = 1'b1; wi++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; blk_ack = 1'b0;
    chk({tag, "_blocks"}, bi, exp_q.size());
    chk({tag, "_words"}, wi, wd.size());
    chk({tag, "_idle"}, {in_ready, blk_valid, blk_first}, 3'b101);
  endtask

  task automatic feed(input int n);
    int k, cyc;
    k = 0; cyc = 0;
    while (k < n && cyc < 500) begin
      @(negedge clk); cyc++;
      in_valid = 1'b0;
      if (in_ready) begin
        in_data = $urandom(); in_bytes = 3'd4; in_last = 1'b0;
        in_valid = 1'b1; k++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("feed_cnt", k, n);
  endtask

  initial begin
    bq_t m;
    bq_t abc;
    string s;
    reset = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    in_bytes = '0; in_last = 1'b0; blk_ack = 1'b0;
    abc = '{8'h61, 8'h62, 8'h63};

    @(negedge clk);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_valid", blk_valid, 1'b0);
    chk("rst_data", blk_data, '0);
    chk("rst_flags", {blk_first, blk_last, err}, 3'b100);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1'b1);

    blk_ack = 1'b1;
    @(negedge clk);
    blk_ack = 1'b0;
    chk("stray_ack", {blk_valid, in_ready, blk_first}, 3'b011);

    in_data = 32'h6162_63AA; in_bytes = 3'd3; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("abc_latency", blk_valid, 1'b1);
    chk("abc_w0", blk_data[31:0], 32'h6162_6380);
    chk("abc_mid", blk_data[479:32], '0);
    chk("abc_w15", blk_data[511:480], 32'h18);
    chk("abc_flags", {blk_first, blk_last}, 2'b11);
    blk_ack = 1'b1;
    @(negedge clk);
    blk_ack = 1'b0;
    chk("abc_after", {in_ready, blk_valid, blk_first}, 3'b101);

    s = "FSOC24/25 is fun!";
    m.delete();
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    send(m, 1, "fsoc");

    m.delete();
    send(m, 0, "empty");
    mk(56, m); send(m, 2, "b56");
    mk(64, m); send(m, 80, "b64");
    mk(55, m); send(m, 0, "b55");
    mk(60, m); send(m, 1, "b60");
    mk(63, m); send(m, 0, "b63");
    mk(128, m); send(m, 0, "b128");

    feed(7);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst", {in_ready, blk_valid, blk_first}, 3'b001);
    @(negedge clk);
    reset = 1'b0;
    send(abc, 0, "abc_after_rst");

    feed(7);
    clr = 1'b1;
    in_data = 32'h6162_6300; in_bytes = 3'd3; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("clr_fill", {blk_valid, in_ready}, 2'b01);
    send(abc, 0, "abc_after_clr_fill");

    feed(16);
    chk("clr_pre", blk_valid, 1'b1);
    clr = 1'b1; blk_ack = 1'b1;
    @(negedge clk);
    clr = 1'b0; blk_ack = 1'b0;
    chk("clr_emit", {blk_valid, in_ready, blk_first}, 3'b011);
    send(abc, 1, "abc_after_clr_emit");

`ifdef SHA1_PAD_ERR_EN
    in_data = 32'h1234_5678; in_bytes = 3'd5; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("err_set", {err, blk_valid, in_ready}, 3'b101);
    @(negedge clk);
    chk("err_sticky", err, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("err_clr", err, 1'b0);
    send(abc, 0, "abc_after_err");
`endif

    for (int t = 0; t < 25; t++) begin
      mk($urandom_range(0, 150), m);
      send(m, $urandom_range(0, 3), "rand");
    end
    chk("err_end", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
